lab2_rr_decoder_arbiter: RTL and testbench
==========================================

Name: lab2_rr_decoder_arbiter

Overview:
- Round-robin arbiter that shares one 2x4 decoder-driven resource, such as a chip-select bus, among four requesters.
- Each cycle it produces the decoder select code, the decoder enable, and a registered one-hot grant (the decoded value).
- Break-before-make: every grant change is separated by one all-off cycle.
- A grant is capped at MAX_HOLD cycles so that no requester can starve the others.

Parameters:
- MAX_HOLD, 8, maximum consecutive cycles one requester may hold the grant; legal range 1..15.
- CNT_W, 4, width of the hold counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request lines; req[i] stays high while requester i wants or uses the resource.
- sel  output  2  decoder select code (index of the granted requester).
- dec_en  output  1  decoder enable; high only while a grant is active.
- gnt  output  4  one-hot grant; equals the 2x4 decode of sel when dec_en=1, else 4'b0000.
- busy  output  1  high while in GRANT state.
- timeout  output  1  one-cycle pulse when a grant is revoked by MAX_HOLD expiry.
- hold_cnt  output  CNT_W  cycles elapsed in the current grant (0 in the first granted cycle).

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-grant):
  - state=IDLE; sel=2'b00, dec_en=0, gnt=0000, busy=0, timeout=0, hold_cnt=0.
  - Internal last=2'b11, so requester 0 has highest priority after reset.
- All outputs are registered; no combinational path from req to any output.
- Arbitration function (used in IDLE and RELEASE):
  - Search order is last+1, last+2, last+3, last, modulo 4.
  - The first i found with req[i]=1 wins.
- State IDLE:
  - If req==0000, stay in IDLE.
  - Otherwise, at the clock edge: go to GRANT; sel=winner, dec_en=1, gnt=onehot(winner), busy=1, hold_cnt=0.
  - Latency: req sampled high at edge N gives gnt high after edge N (one cycle from the req assertion cycle).
- State GRANT: at each edge, evaluate in this order:
  1. If req[sel]=0, go to RELEASE (normal release).
  2. Else if hold_cnt==MAX_HOLD-1, go to RELEASE and set timeout=1 for that cycle (expiry).
  3. Else hold_cnt increments by 1; sel, gnt and dec_en are unchanged.
  - Changes on other req lines during GRANT are ignored; no preemption.
- Entering RELEASE: dec_en=0, gnt=0000, busy=0, hold_cnt=0, last=sel. sel holds its value.
- State RELEASE (always exactly one cycle):
  - If any req is high, arbitrate and go directly to GRANT as in IDLE.
  - Otherwise go to IDLE.
  - timeout is cleared on exit.
- Boundary conditions:
  - MAX_HOLD=1: every grant lasts exactly one cycle; timeout pulses whenever the requester still holds req.
  - A lone requester that times out while still requesting is regranted after exactly one dead cycle; hold_cnt restarts at 0.
  - Simultaneous drop of req[sel] and expiry: treated as a normal release, timeout=0.
  - All four requesting continuously: grant rotates 0,1,2,3,0,..., each for MAX_HOLD cycles, with one gap cycle between grants.
  - A req that rises and falls between edges is never seen.
- Invariants:
  - gnt is always either 0000 or one-hot.
  - gnt==0000 exactly when dec_en==0.
  - gnt==onehot(sel) whenever dec_en==1.

Test Plan:
- Reset then req=0000 for 5 cycles -> gnt=0000, dec_en=0, sel=00, busy=0 throughout. Assert rst_n=0 mid-grant -> all outputs clear immediately, without waiting for a clock edge.
- req=0100 held for 3 cycles then 0000 -> next edge gnt=0100, sel=10, dec_en=1; hold_cnt 0,1,2; one RELEASE cycle with gnt=0000; then IDLE; timeout stays 0.
- req=1111 held for 40 cycles, MAX_HOLD=8 -> grants 0001,0010,0100,1000,0001 in order, each 8 cycles with a 1-cycle gap; timeout pulses at each revocation.
- req=0001 held continuously, MAX_HOLD=8 -> gnt=0001 for 8 cycles, timeout=1 with gnt=0000 for one cycle, then gnt=0001 again with hold_cnt=0.
- Grant to requester 2 active, then req goes 0100 -> 1101 -> next edge gnt stays 0100 (no preemption). Drop req[2] -> after the gap cycle gnt=1000 (requester 3 wins over 0).
- MAX_HOLD=1, req=0011 held -> gnt alternates 0001, 0000, 0010, 0000, 0001; timeout=1 in every gap cycle.

Source files
------------

// File: rtl/lab2_rr_decoder_arbiter_if.sv
// lab2_rr_decoder_arbiter_if: request/grant bundle between four requesters and the arbiter
//   req      : request lines, requester i drives req[i]
//   sel      : decoder select code (granted index)
//   dec_en   : decoder enable, high while a grant is active
//   gnt      : one-hot grant (decoded sel), 0000 when dec_en is low
//   busy     : arbiter is in its GRANT state
//   timeout  : one-cycle pulse when a grant is revoked by hold-limit expiry
//   hold_cnt : cycles elapsed in the current grant
interface lab2_rr_decoder_arbiter_if #(parameter int CNT_W = 4);
   logic [3:0]       req;
   logic [1:0]       sel;
   logic             dec_en;
   logic [3:0]       gnt;
   logic             busy;
   logic             timeout;
   logic [CNT_W-1:0] hold_cnt;
   modport master (output req, input sel, dec_en, gnt, busy, timeout, hold_cnt);
   modport slave  (input req, output sel, dec_en, gnt, busy, timeout, hold_cnt);
endinterface

// File: rtl/lab2_rr_decoder_arbiter.sv
// lab2_rr_decoder_arbiter: round-robin, break-before-make arbiter driving a shared 2x4 decoder
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of lab2_rr_decoder_arbiter_if (req in; sel, dec_en, gnt, busy,
//           timeout, hold_cnt out, all registered)
module lab2_rr_decoder_arbiter #(
   parameter int MAX_HOLD = 8,
   parameter int CNT_W    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   lab2_rr_decoder_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
   state_t           state, state_nxt;
   logic [1:0]       sel, sel_nxt, last, last_nxt, win;
   logic             dec_en, dec_en_nxt, timeout, timeout_nxt;
   logic [3:0]       gnt, gnt_nxt;
   logic [CNT_W-1:0] hold_cnt, hold_cnt_nxt;
   // Scan from last+4 (== last) down to last+1 so the lowest offset found wins,
   // giving the order last+1, last+2, last+3, last.
   always_comb begin
      win = last;
      for (int k = 4; k >= 1; k--)
         if (bus.req[last + 2'(k)]) win = last + 2'(k);
   end
   always_comb begin
      state_nxt    = state;
      sel_nxt      = sel;
      last_nxt     = last;
      dec_en_nxt   = dec_en;
      hold_cnt_nxt = hold_cnt;
      timeout_nxt  = 1'b0;
      case (state)
         GRANT: begin
            if (!bus.req[sel] || hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
               // a dropped request takes precedence, so expiry only flags timeout
               // when the owner is still asking
               state_nxt    = RELEASE;
               dec_en_nxt   = 1'b0;
               hold_cnt_nxt = '0;
               last_nxt     = sel;
               timeout_nxt  = bus.req[sel];
            end else begin
               hold_cnt_nxt = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt    = |bus.req ? GRANT : IDLE;
            sel_nxt      = |bus.req ? win : sel;
            dec_en_nxt   = |bus.req;
            hold_cnt_nxt = '0;
         end
      endcase
      gnt_nxt = dec_en_nxt ? 4'b0001 << sel_nxt : 4'b0000;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         sel      <= 2'b00;
         last     <= 2'b11;
         dec_en   <= 1'b0;
         gnt      <= 4'b0000;
         timeout  <= 1'b0;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         sel      <= sel_nxt;
         last     <= last_nxt;
         dec_en   <= dec_en_nxt;
         gnt      <= gnt_nxt;
         timeout  <= timeout_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end
   assign bus.sel      = sel;
   assign bus.dec_en   = dec_en;
   assign bus.gnt      = gnt;
   assign bus.busy     = state == GRANT;
   assign bus.timeout  = timeout;
   assign bus.hold_cnt = hold_cnt;
endmodule

// File: tb/tb_lab2_rr_decoder_arbiter.sv
// tb_lab2_rr_decoder_arbiter: directed bench for the round-robin decoder arbiter
//   u_dut  : MAX_HOLD=8 instance on bus a
//   u_dut1 : MAX_HOLD=1 instance on bus b
module tb_lab2_rr_decoder_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   lab2_rr_decoder_arbiter_if #(.CNT_W(4)) a ();
   lab2_rr_decoder_arbiter_if #(.CNT_W(4)) b ();
   lab2_rr_decoder_arbiter #(.MAX_HOLD(8), .CNT_W(4)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(a));
   lab2_rr_decoder_arbiter #(.MAX_HOLD(1), .CNT_W(4)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b));
   always #5 clk = ~clk;
   // gnt must be 0000 with dec_en low, onehot(sel) with dec_en high
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (a.gnt !== (a.dec_en ? 4'b0001 << a.sel : 4'b0000)) begin
            failures++;
            $display("FAIL invariant_a gnt=%b dec_en=%b sel=%0d", a.gnt, a.dec_en, a.sel);
         end
         checks++;
         if (b.gnt !== (b.dec_en ? 4'b0001 << b.sel : 4'b0000)) begin
            failures++;
            $display("FAIL invariant_b gnt=%b dec_en=%b sel=%0d", b.gnt, b.dec_en, b.sel);
         end
      end
   end
   task automatic apply_reset();
      rst_n = 1'b0;
      a.req = 4'b0000;
      b.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask
   task automatic test_reset();
      logic [12:0] got;
      apply_reset();
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         got = {a.sel, a.dec_en, a.gnt, a.busy, a.timeout, a.hold_cnt};
         checks++;
         if (got !== 13'd0) begin
            failures++;
            $display("FAIL reset_idle cycle=%0d got=%h exp=0", i, got);
         end
      end
      a.req = 4'b0001;
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0001 || a.busy !== 1'b1) begin
         failures++;
         $display("FAIL pre_async_grant gnt=%b busy=%b exp gnt=0001 busy=1", a.gnt, a.busy);
      end
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      got = {a.sel, a.dec_en, a.gnt, a.busy, a.timeout, a.hold_cnt};
      checks++;
      if (got !== 13'd0) begin
         failures++;
         $display("FAIL async_reset got=%h exp=0", got);
      end
      a.req = 4'b0000;
      #2 rst_n = 1'b1;
   endtask
   task automatic test_single();
      apply_reset();
      a.req = 4'b0100;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (a.gnt !== 4'b0100 || a.sel !== 2'd2 || a.dec_en !== 1'b1 || a.hold_cnt !== 4'(i) || a.timeout !== 1'b0) begin
            failures++;
            $display("FAIL single_grant cycle=%0d gnt=%b sel=%0d en=%b cnt=%0d to=%b exp gnt=0100 sel=2 en=1 cnt=%0d to=0",
                     i, a.gnt, a.sel, a.dec_en, a.hold_cnt, a.timeout, i);
         end
      end
      a.req = 4'b0000;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         checks++;
         if (a.gnt !== 4'b0000 || a.busy !== 1'b0 || a.timeout !== 1'b0 || a.sel !== 2'd2) begin
            failures++;
            $display("FAIL single_release cycle=%0d gnt=%b busy=%b to=%b sel=%0d exp gnt=0000 busy=0 to=0 sel=2",
                     i, a.gnt, a.busy, a.timeout, a.sel);
         end
      end
   endtask
   task automatic test_all_four();
      logic [3:0] eg;
      logic       et;
      int         pos;
      apply_reset();
      a.req = 4'b1111;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         pos = c % 9;
         eg  = pos < 8 ? 4'b0001 << ((c / 9) % 4) : 4'b0000;
         et  = pos == 8;
         checks++;
         if (a.gnt !== eg || a.timeout !== et || (pos < 8 && a.hold_cnt !== 4'(pos))) begin
            failures++;
            $display("FAIL all_four cycle=%0d gnt=%b to=%b cnt=%0d exp gnt=%b to=%b cnt=%0d",
                     c, a.gnt, a.timeout, a.hold_cnt, eg, et, pos);
         end
      end
      a.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_lone_timeout();
      apply_reset();
      a.req = 4'b0001;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         checks++;
         if (a.gnt !== 4'b0001 || a.hold_cnt !== 4'(i) || a.timeout !== 1'b0) begin
            failures++;
            $display("FAIL lone_hold cycle=%0d gnt=%b cnt=%0d to=%b exp gnt=0001 cnt=%0d to=0", i, a.gnt, a.hold_cnt, a.timeout, i);
         end
      end
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0000 || a.timeout !== 1'b1 || a.busy !== 1'b0) begin
         failures++;
         $display("FAIL lone_expiry gnt=%b to=%b busy=%b exp gnt=0000 to=1 busy=0", a.gnt, a.timeout, a.busy);
      end
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0001 || a.hold_cnt !== 4'd0 || a.timeout !== 1'b0) begin
         failures++;
         $display("FAIL lone_regrant gnt=%b cnt=%0d to=%b exp gnt=0001 cnt=0 to=0", a.gnt, a.hold_cnt, a.timeout);
      end
      a.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_drop_at_expiry();
      apply_reset();
      a.req = 4'b0010;
      repeat (8) @(posedge clk);
      #1;
      checks++;
      if (a.gnt !== 4'b0010 || a.hold_cnt !== 4'd7) begin
         failures++;
         $display("FAIL drop_pre gnt=%b cnt=%0d exp gnt=0010 cnt=7", a.gnt, a.hold_cnt);
      end
      a.req = 4'b0000;
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0000 || a.timeout !== 1'b0) begin
         failures++;
         $display("FAIL drop_at_expiry gnt=%b to=%b exp gnt=0000 to=0", a.gnt, a.timeout);
      end
      @(posedge clk); #1;
   endtask
   task automatic test_no_preempt();
      apply_reset();
      a.req = 4'b0100;
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0100) begin
         failures++;
         $display("FAIL preempt_first gnt=%b exp=0100", a.gnt);
      end
      a.req = 4'b1101;
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0100 || a.hold_cnt !== 4'd1) begin
         failures++;
         $display("FAIL no_preempt gnt=%b cnt=%0d exp gnt=0100 cnt=1", a.gnt, a.hold_cnt);
      end
      a.req = 4'b1001;
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b0000) begin
         failures++;
         $display("FAIL preempt_gap gnt=%b exp=0000", a.gnt);
      end
      @(posedge clk); #1;
      checks++;
      if (a.gnt !== 4'b1000 || a.sel !== 2'd3) begin
         failures++;
         $display("FAIL rr_next gnt=%b sel=%0d exp gnt=1000 sel=3", a.gnt, a.sel);
      end
      a.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
   endtask
   task automatic test_max_hold_one();
      logic [3:0] eg [5] = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0001};
      logic       et [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      apply_reset();
      b.req = 4'b0011;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (b.gnt !== eg[i] || b.timeout !== et[i]) begin
            failures++;
            $display("FAIL hold_one cycle=%0d gnt=%b to=%b exp gnt=%b to=%b", i, b.gnt, b.timeout, eg[i], et[i]);
         end
      end
      b.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
   endtask
   initial begin
      a.req = 4'b0000;
      b.req = 4'b0000;
      test_reset();
      test_single();
      test_all_four();
      test_lone_timeout();
      test_drop_at_expiry();
      test_no_preempt();
      test_max_hold_one();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
